// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parametrised PISO serializer: bit-order selectors
// and the shifter FSM state encoding.
package piso_serializer_pkg;

    localparam int BIT_ORDER_LSB = 0;
    localparam int BIT_ORDER_MSB = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage : piso_serializer_pkg

// File: rtl/piso_serializer_if.sv
// Word-side handshake plus serial-side outputs of the PISO serializer.
// The master modport is the word producer / serial consumer; the slave is the serializer.
interface piso_serializer_if #(
    parameter int WIDTH = 4
) ();
    import piso_serializer_pkg::*;

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             piso_done;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  ser_out,
        input  ser_valid,
        input  ser_first,
        input  ser_last,
        input  piso_done,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output ser_out,
        output ser_valid,
        output ser_first,
        output ser_last,
        output piso_done,
        output busy
    );

endinterface : piso_serializer_if

// File: rtl/piso_hold_buf.sv
// One-entry holding register that parks a word while the shifter is busy.
// load_i fills the entry, take_i empties it; the owner never asserts both at once.
module piso_hold_buf
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             load_i,
    input  logic             take_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o
);

    logic [WIDTH-1:0] data_q;
    logic             full_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else if (load_i) begin
            data_q <= data_i;
            full_q <= 1'b1;
        end else if (take_i) begin
            full_q <= 1'b0;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule : piso_hold_buf

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: accepts WIDTH-bit words on valid/ready and emits
// one registered bit per clock, with a one-word hold buffer for gap-free streaming.
module piso_serializer
    import piso_serializer_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MSB_FIRST  = BIT_ORDER_LSB,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    piso_serializer_if.slave   bus
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             ser_out_q;
    logic             ser_valid_q;
    logic             ser_first_q;
    logic             ser_last_q;
    logic             done_q;

    logic [WIDTH-1:0] hold_data;
    logic             hold_full;
    logic             transfer;
    logic             last_bit;
    logic             shifter_free;
    logic             load_shift;
    logic             load_hold;
    logic             take_hold;
    logic             next_bit;
    logic [WIDTH-1:0] shreg_shifted;

    // Bit selection and shift direction are fixed at elaboration.
    generate
        if (MSB_FIRST == BIT_ORDER_MSB) begin : g_msb_first
            assign next_bit      = shreg_q[WIDTH-1];
            assign shreg_shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign next_bit      = shreg_q[0];
            assign shreg_shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    endgenerate

    assign count_d      = count_q + 1'b1;
    assign transfer     = bus.in_valid & ~hold_full;
    assign last_bit     = (state_q == ST_SHIFT) && (count_q == CNT_LAST);
    // A shifter emitting its last bit this edge can take a new word with no bubble.
    assign shifter_free = (state_q == ST_IDLE) || last_bit;
    assign load_shift   = transfer & shifter_free;
    assign load_hold    = transfer & ~shifter_free;
    assign take_hold    = last_bit & hold_full;

    piso_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk    (clk),
        .rst    (rst),
        .data_i (bus.in_data),
        .load_i (load_hold),
        .take_i (take_hold),
        .data_o (hold_data),
        .full_o (hold_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            count_q     <= '0;
            ser_out_q   <= IDLE_LEVEL;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            ser_out_q   <= IDLE_LEVEL;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
            done_q      <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (load_shift) begin
                        state_q <= ST_SHIFT;
                        shreg_q <= bus.in_data;
                        count_q <= '0;
                    end
                end
                ST_SHIFT: begin
                    ser_out_q   <= next_bit;
                    ser_valid_q <= 1'b1;
                    ser_first_q <= (count_q == '0);
                    shreg_q     <= shreg_shifted;
                    count_q     <= count_d;
                    if (last_bit) begin
                        ser_last_q <= 1'b1;
                        done_q     <= 1'b1;
                        count_q    <= '0;
                        // Hold word has priority; it was accepted earlier than any new one.
                        if (hold_full) begin
                            shreg_q <= hold_data;
                        end else if (load_shift) begin
                            shreg_q <= bus.in_data;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = ~hold_full;
    assign bus.ser_out   = ser_out_q;
    assign bus.ser_valid = ser_valid_q;
    assign bus.ser_first = ser_first_q;
    assign bus.ser_last  = ser_last_q;
    assign bus.piso_done = done_q;
    assign bus.busy      = (state_q == ST_SHIFT) | hold_full;

endmodule : piso_serializer

// File: tb/tb_piso_serializer.sv
// Self-checking bench: three serializer configurations checked cycle by cycle
// against a bit-queue model of the serial stream.
module tb_piso_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        drv_valid = 1'b0;
    logic [63:0] drv_data  = '0;
    int          sel     = 0;
    int          cur_w   = 8;
    bit          cur_msb = 1'b0;
    bit          cur_idle = 1'b0;

    always #5 clk = ~clk;

    piso_serializer_if #(.WIDTH(8)) if8l ();
    piso_serializer_if #(.WIDTH(8)) if8m ();
    piso_serializer_if #(.WIDTH(4)) if4  ();

    piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut8l (.clk(clk), .rst(rst), .bus(if8l));
    piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b1)) dut8m (.clk(clk), .rst(rst), .bus(if8m));
    piso_serializer #(.WIDTH(4), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut4  (.clk(clk), .rst(rst), .bus(if4));

    assign if8l.in_valid = drv_valid && (sel == 0);
    assign if8m.in_valid = drv_valid && (sel == 1);
    assign if4.in_valid  = drv_valid && (sel == 2);
    assign if8l.in_data  = drv_data[7:0];
    assign if8m.in_data  = drv_data[7:0];
    assign if4.in_data   = drv_data[3:0];

    // {ser_valid, ser_out, ser_first, ser_last, piso_done, in_ready, busy}
    logic [6:0] obs;
    always_comb begin
        case (sel)
            1:       obs = {if8m.ser_valid, if8m.ser_out, if8m.ser_first, if8m.ser_last,
                            if8m.piso_done, if8m.in_ready, if8m.busy};
            2:       obs = {if4.ser_valid, if4.ser_out, if4.ser_first, if4.ser_last,
                            if4.piso_done, if4.in_ready, if4.busy};
            default: obs = {if8l.ser_valid, if8l.ser_out, if8l.ser_first, if8l.ser_last,
                            if8l.piso_done, if8l.in_ready, if8l.busy};
        endcase
    end

    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc   = 0;
    logic [6:0] expv;
    bit         accepted;
    // Pending serial bits, each {data, first, last}; the block can take a word
    // whenever no more than one word's worth of bits is still waiting.
    logic [2:0] bq[$];

    task automatic select_dut(input int s);
        sel      = s;
        cur_w    = (s == 2) ? 4 : 8;
        cur_msb  = (s == 1);
        cur_idle = (s == 1);
        bq.delete();
    endtask

    task automatic cycle(input bit v, input logic [63:0] d);
        logic [2:0] e;
        bit acc;
        drv_valid = v;
        drv_data  = d;
        acc = v && (bq.size() <= cur_w);
        @(posedge clk);
        if (bq.size() != 0) begin
            e = bq.pop_front();
            expv[6:2] = {1'b1, e[2], e[1], e[0], e[0]};
        end else begin
            expv[6:2] = {1'b0, cur_idle, 3'b000};
        end
        if (acc) begin
            for (int i = 0; i < cur_w; i++)
                bq.push_back({d[cur_msb ? (cur_w - 1 - i) : i], (i == 0), (i == cur_w - 1)});
        end
        expv[1]  = (bq.size() <= cur_w);
        expv[0]  = (bq.size() != 0);
        accepted = acc;
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            select_dut(s);
            #1;
            n_cmp++;
            if (obs !== {1'b0, cur_idle, 3'b000, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL reset dut=%0d got=%b want=%b", s, obs, {1'b0, cur_idle, 3'b000, 1'b1, 1'b0});
            end
        end
    endtask

    task automatic test_lsb_a5();
        logic [7:0] got = '0;
        select_dut(0);
        for (int i = 0; i < 10; i++) begin
            cycle(i == 0, 64'hA5);
            if (obs[6]) got = {obs[5], got[7:1]};
            n_cmp++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL lsb_a5 cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
        n_cmp++;
        if (got !== 8'hA5) begin
            n_bad++;
            $display("FAIL lsb_a5_word got=%h want=a5", got);
        end
    endtask

    task automatic test_msb();
        logic [7:0] words [2] = '{8'hA5, 8'h3C};
        logic [7:0] got;
        select_dut(1);
        for (int w = 0; w < 2; w++) begin
            got = '0;
            for (int i = 0; i < 10; i++) begin
                cycle(i == 0, {56'd0, words[w]});
                if (obs[6]) got = {got[6:0], obs[5]};
                n_cmp++;
                if (obs !== expv) begin
                    n_bad++;
                    $display("FAIL msb cyc=%0d got=%b want=%b", cyc, obs, expv);
                end
            end
            n_cmp++;
            if (got !== words[w]) begin
                n_bad++;
                $display("FAIL msb_word got=%h want=%h", got, words[w]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] words [2] = '{64'h12, 64'h34};
        int idx = 0, run = 0, best = 0, dones = 0;
        select_dut(0);
        for (int i = 0; i < 24; i++) begin
            cycle(idx < 2, words[idx < 2 ? idx : 1]);
            if (accepted) idx++;
            run  = obs[6] ? run + 1 : 0;
            best = (run > best) ? run : best;
            if (obs[2]) dones++;
            n_cmp++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL back_to_back cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
        n_cmp++;
        if (best !== 16 || dones !== 2) begin
            n_bad++;
            $display("FAIL b2b_stream run=%0d dones=%0d want run=16 dones=2", best, dones);
        end
    endtask

    task automatic test_three_words();
        int idx = 0;
        bit low_seen = 0, last_seen = 0;
        select_dut(0);
        for (int i = 0; i < 34; i++) begin
            cycle(idx < 3, {$urandom, $urandom});
            if (accepted) idx++;
            if (obs[1] === 1'b0) low_seen = 1;
            if (obs[3] === 1'b1 && !last_seen) begin
                last_seen = 1;
                n_cmp++;
                if (!(low_seen && obs[1] === 1'b1)) begin
                    n_bad++;
                    $display("FAIL three_ready low_seen=%0d ready_at_last=%b want 1 and 1", low_seen, obs[1]);
                end
            end
            n_cmp++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL three_words cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_reset_mid();
        select_dut(0);
        for (int i = 0; i < 5; i++) begin
            cycle(i < 2, (i == 0) ? 64'hFF : {$urandom, $urandom});
            n_cmp++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL rst_mid_pre cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
        #2 rst = 1'b1;
        bq.delete();
        #1;
        n_cmp++;
        if (obs !== 7'b0000010) begin
            n_bad++;
            $display("FAIL rst_mid_async got=%b want=0000010", obs);
        end
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (obs !== 7'b0000010) begin
            n_bad++;
            $display("FAIL rst_mid_held got=%b want=0000010", obs);
        end
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(i == 0, {$urandom, $urandom});
            n_cmp++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL rst_mid_post cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
    endtask

    task automatic test_w4();
        logic [3:0] got = '0;
        select_dut(2);
        for (int i = 0; i < 6; i++) begin
            cycle(i == 0, 64'h6);
            if (obs[6]) got = {obs[5], got[3:1]};
            n_cmp++;
            if (obs !== expv) begin
                n_bad++;
                $display("FAIL w4 cyc=%0d got=%b want=%b", cyc, obs, expv);
            end
        end
        n_cmp++;
        if (got !== 4'h6) begin
            n_bad++;
            $display("FAIL w4_word got=%h want=6", got);
        end
    endtask

    task automatic test_random();
        for (int s = 0; s < 3; s++) begin
            select_dut(s);
            for (int i = 0; i < 320; i++) begin
                cycle((i < 300) && ($urandom_range(0, 3) != 0), {$urandom, $urandom});
                n_cmp++;
                if (obs !== expv) begin
                    n_bad++;
                    $display("FAIL random dut=%0d cyc=%0d got=%b want=%b", s, cyc, obs, expv);
                end
            end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(negedge clk);
        test_lsb_a5();
        test_msb();
        test_back_to_back();
        test_three_words();
        test_reset_mid();
        test_w4();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_piso_serializer
